// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage: PC, imem req/ack reads, IF/ID register, stall skid and branch flush
module fetch_stage #(
  parameter int                      PC_WIDTH    = 8,
  parameter int                      INSTR_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0]     RESET_PC    = '0,
  parameter logic [INSTR_WIDTH-1:0]  NOP_INSTR   = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   stall,
  input  logic                   flush,
  input  logic [PC_WIDTH-1:0]    branch_target,
  output logic                   imem_req,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  input  logic                   imem_ack,
  output logic [INSTR_WIDTH-1:0] instr_out,
  output logic [PC_WIDTH-1:0]    pc_out,
  output logic                   instr_valid
);

  // FULL means the skid holds one word; skid occupancy is the state itself
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FULL = 2'd2
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [PC_WIDTH-1:0]    pc;
  logic [INSTR_WIDTH-1:0] skid_data;
  logic [PC_WIDTH-1:0]    skid_addr;
  // set when a flush lands while a read is outstanding; the late ack is dropped
  logic                   discard;

  assign imem_req = (state == REQ);

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next-state: an ack under stall parks the word in the skid, flush always returns to REQ
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: state_nxt = REQ;
      REQ: begin
        if (imem_ack && !flush && !discard && stall) begin
          state_nxt = FULL;
        end
      end
      FULL: begin
        if (flush || !stall) begin
          state_nxt = REQ;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // PC, request address, skid and IF/ID register updates
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      imem_addr   <= '0;
      instr_out   <= NOP_INSTR;
      pc_out      <= '0;
      instr_valid <= 1'b0;
      skid_data   <= NOP_INSTR;
      skid_addr   <= '0;
      discard     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (flush) begin
            pc          <= branch_target;
            imem_addr   <= branch_target;
            instr_out   <= NOP_INSTR;
            instr_valid <= 1'b0;
          end else begin
            imem_addr <= pc;
          end
        end
        REQ: begin
          if (flush) begin
            instr_out   <= NOP_INSTR;
            instr_valid <= 1'b0;
            pc          <= branch_target;
            if (imem_ack) begin
              // the returning word is from the wrong path; restart at the target now
              imem_addr <= branch_target;
              discard   <= 1'b0;
            end else begin
              // address must stay put until the outstanding read completes
              discard <= 1'b1;
            end
          end else if (imem_ack) begin
            if (discard) begin
              discard   <= 1'b0;
              imem_addr <= pc;
            end else if (stall) begin
              skid_data <= imem_rdata;
              skid_addr <= imem_addr;
              pc        <= pc + 1'b1;
            end else begin
              instr_out   <= imem_rdata;
              pc_out      <= imem_addr;
              instr_valid <= 1'b1;
              pc          <= pc + 1'b1;
              imem_addr   <= pc + 1'b1;
            end
          end
        end
        FULL: begin
          if (flush) begin
            instr_out   <= NOP_INSTR;
            instr_valid <= 1'b0;
            pc          <= branch_target;
            imem_addr   <= branch_target;
          end else if (!stall) begin
            instr_out   <= skid_data;
            pc_out      <= skid_addr;
            instr_valid <= 1'b1;
            imem_addr   <= pc;
          end
        end
        default: begin
          discard <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - table-driven and scoreboard checks for fetch_stage
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        flush;
  logic [7:0]  branch_target;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_ack;
  logic [15:0] instr_out;
  logic [7:0]  pc_out;
  logic        instr_valid;
  logic        ack_en;

  int checks;
  int fails;

  fetch_stage #(
    .PC_WIDTH(8),
    .INSTR_WIDTH(16),
    .RESET_PC(8'h00),
    .NOP_INSTR(16'h0000)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .stall(stall),
    .flush(flush),
    .branch_target(branch_target),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_rdata(imem_rdata),
    .imem_ack(imem_ack),
    .instr_out(instr_out),
    .pc_out(pc_out),
    .instr_valid(instr_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // instruction memory contents
  function automatic logic [15:0] word(input logic [7:0] a);
    if (a == 8'h05) return 16'hA005;
    if (a == 8'h07) return 16'hDEAD;
    return 16'h1001 + {8'h00, a};
  endfunction

  // zero-wait responder: ack only while a request is up
  assign imem_ack   = ack_en & imem_req;
  assign imem_rdata = word(imem_addr);

  typedef struct {
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic [7:0]  bt;
    logic        ack;
    logic        push;
    logic        req;
    logic [7:0]  addr;
    logic        valid;
    logic [15:0] instr;
    logic [7:0]  pc;
  } vec_t;

  typedef struct {
    logic [15:0] instr;
    logic [7:0]  pc;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb_q[$];

  function automatic vec_t v(input logic r, input logic s, input logic f, input logic [7:0] bt,
                             input logic a, input logic p, input logic rq, input logic [7:0] ad,
                             input logic vl, input logic [15:0] ins, input logic [7:0] pcv);
    vec_t t;
    t.rst_n = r; t.stall = s; t.flush = f; t.bt = bt; t.ack = a; t.push = p;
    t.req = rq; t.addr = ad; t.valid = vl; t.instr = ins; t.pc = pcv;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard monitor: every new instruction presented to decode must match the queue head
  logic       last_valid;
  logic [7:0] last_pc;
  initial begin
    last_valid = 1'b0;
    last_pc    = 8'h00;
  end
  always @(negedge clk) begin
    if (instr_valid && (!last_valid || pc_out != last_pc)) begin
      if (sb_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL sb_unexpected: got instr %0h pc %0h with empty queue", instr_out, pc_out);
      end else begin
        sb_t e;
        e = sb_q.pop_front();
        check("sb_instr", {16'h0, instr_out}, {16'h0, e.instr});
        check("sb_pc", {24'h0, pc_out}, {24'h0, e.pc});
      end
    end
    last_valid = instr_valid;
    last_pc    = pc_out;
  end

  initial begin
    // args: rst stall flush bt ack push | req addr valid instr pc
    vecs.push_back(v(0,0,0,8'h00,0,0, 0,8'h00,0,16'h0000,8'h00)); // reset state
    // 1: zero-wait stream
    vecs.push_back(v(1,0,0,8'h00,0,0, 1,8'h00,0,16'h0000,8'h00));
    vecs.push_back(v(1,0,0,8'h00,1,1, 1,8'h01,1,16'h1001,8'h00));
    vecs.push_back(v(1,0,0,8'h00,1,1, 1,8'h02,1,16'h1002,8'h01));
    vecs.push_back(v(1,0,0,8'h00,1,1, 1,8'h03,1,16'h1003,8'h02));
    vecs.push_back(v(1,0,0,8'h00,1,1, 1,8'h04,1,16'h1004,8'h03));
    vecs.push_back(v(1,0,0,8'h00,1,1, 1,8'h05,1,16'h1005,8'h04));
    // 2: ack under stall lands in skid, released after 3 stall cycles
    vecs.push_back(v(1,1,0,8'h00,1,0, 0,8'h00,1,16'h1005,8'h04));
    vecs.push_back(v(1,1,0,8'h00,0,0, 0,8'h00,1,16'h1005,8'h04));
    vecs.push_back(v(1,1,0,8'h00,0,0, 0,8'h00,1,16'h1005,8'h04));
    vecs.push_back(v(1,0,0,8'h00,0,1, 1,8'h06,1,16'hA005,8'h05));
    vecs.push_back(v(1,0,0,8'h00,1,1, 1,8'h07,1,16'h1007,8'h06));
    // 3: flush while addr 7 outstanding, ack two cycles late is dropped
    vecs.push_back(v(1,0,1,8'h40,0,0, 1,8'h07,0,16'h0000,8'h00));
    vecs.push_back(v(1,0,0,8'h00,0,0, 1,8'h07,0,16'h0000,8'h00));
    vecs.push_back(v(1,0,0,8'h00,1,0, 1,8'h40,0,16'h0000,8'h00));
    vecs.push_back(v(1,0,0,8'h00,1,1, 1,8'h41,1,16'h1041,8'h40));
    // 4: flush + stall + ack together: flush wins, skid stays empty
    vecs.push_back(v(1,1,1,8'h20,1,0, 1,8'h20,0,16'h0000,8'h00));
    vecs.push_back(v(1,0,0,8'h00,1,1, 1,8'h21,1,16'h1021,8'h20));
    // 5: PC wrap FF -> 00
    vecs.push_back(v(1,0,1,8'hFE,1,0, 1,8'hFE,0,16'h0000,8'h00));
    vecs.push_back(v(1,0,0,8'h00,1,1, 1,8'hFF,1,16'h10FF,8'hFE));
    vecs.push_back(v(1,0,0,8'h00,1,1, 1,8'h00,1,16'h1100,8'hFF));
    vecs.push_back(v(1,0,0,8'h00,1,1, 1,8'h01,1,16'h1001,8'h00));
    // 6: reset mid-REQ with ack, then fetch restarts at RESET_PC
    vecs.push_back(v(0,0,0,8'h00,1,0, 0,8'h00,0,16'h0000,8'h00));
    vecs.push_back(v(1,0,0,8'h00,0,0, 1,8'h00,0,16'h0000,8'h00));
    vecs.push_back(v(1,0,0,8'h00,1,1, 1,8'h01,1,16'h1001,8'h00));
    // flush out of FULL redirects to the target
    vecs.push_back(v(1,1,0,8'h00,1,0, 0,8'h00,1,16'h1001,8'h00));
    vecs.push_back(v(1,1,1,8'h80,0,0, 1,8'h80,0,16'h0000,8'h00));
    vecs.push_back(v(1,0,0,8'h00,1,1, 1,8'h81,1,16'h1081,8'h80));

    checks = 0;
    fails  = 0;
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; branch_target = 8'h00; ack_en = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      vec_t t;
      t = vecs[i];
      rst_n         = t.rst_n;
      stall         = t.stall;
      flush         = t.flush;
      branch_target = t.bt;
      ack_en        = t.ack;
      if (t.push) begin
        sb_t e;
        e.instr = t.instr;
        e.pc    = t.pc;
        sb_q.push_back(e);
      end
      @(posedge clk);
      #1;
      check($sformatf("row%0d_req", i), {31'h0, imem_req}, {31'h0, t.req});
      check($sformatf("row%0d_valid", i), {31'h0, instr_valid}, {31'h0, t.valid});
      check($sformatf("row%0d_instr", i), {16'h0, instr_out}, {16'h0, t.instr});
      if (t.req || !t.rst_n)
        check($sformatf("row%0d_addr", i), {24'h0, imem_addr}, {24'h0, t.addr});
      if (t.valid || !t.rst_n)
        check($sformatf("row%0d_pc", i), {24'h0, pc_out}, {24'h0, t.pc});
    end

    ack_en = 1'b0;
    stall  = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("sb_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
